// File: rtl/mem_access_unit.sv
// mem_access_unit: registered, handshaked load/store stage between execute
// and writeback. One op is accepted from execute, the bus request is held
// stable until the bus returns data_ok, and the load data is aligned,
// extended and offered to writeback.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned or oversized accesses skip the bus and report out_fault
//   undefined : misaligned low address bits are cleared, oversized size is clamped
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready, in_op, in_addr, in_wdata, in_size, in_unsigned : request from execute
//   flush                                                       : kill the in-flight op
//   dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data    : bus request
//   dresp_data_ok, dresp_data                                   : bus response
//   out_valid/out_ready, out_rdata, out_fault                   : result to writeback
module mem_access_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [2:0]            in_size,
  input  logic                  in_unsigned,
  input  logic                  flush,
  output logic                  dreq_valid,
  output logic [ADDR_W-1:0]     dreq_addr,
  output logic [2:0]            dreq_size,
  output logic [DATA_W/8-1:0]   dreq_strobe,
  output logic [DATA_W-1:0]     dreq_data,
  input  logic                  dresp_data_ok,
  input  logic [DATA_W-1:0]     dresp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_rdata,
  output logic                  out_fault
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam logic [2:0] MAX_SIZE = 3'(LB);

  typedef enum logic [1:0] {IDLE, BUS, DRAIN, RESP} state_t;
  state_t state;

  logic              lat_load;
  logic              lat_unsigned;
  logic              accept;

  // Request as it will be latched on accept
  logic              acc_is_mem;
  logic              acc_is_store;
  logic              acc_fault;
  logic [2:0]        size_eff;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] acc_addr;
  logic [LB-1:0]     acc_off;
  logic [NB-1:0]     lo_mask;
  logic [NB-1:0]     acc_strobe;
  logic [DATA_W-1:0] acc_data;

  // Load alignment/extension of the bus response
  logic [LB-1:0]     ld_off;
  logic [DATA_W-1:0] ld_raw;
  logic              ld_sign;
  logic [31:0]       ld_nbits;
  logic [DATA_W-1:0] load_ext;

  assign in_ready = ~flush & ((state == IDLE) | ((state == RESP) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    acc_is_mem   = in_op[1];
    acc_is_store = (in_op == 2'b11);
    size_eff     = (in_size > MAX_SIZE) ? MAX_SIZE : in_size;
    size_mask    = (ADDR_W'(1) << size_eff) - ADDR_W'(1);
`ifdef MEM_MISALIGN_TRAP_EN
    acc_addr  = in_addr;
    acc_fault = acc_is_mem & ((in_size > MAX_SIZE) | (|(in_addr & size_mask)));
`else
    acc_addr  = in_addr & ~size_mask;
    acc_fault = 1'b0;
`endif
    acc_off = acc_addr[LB-1:0];
    for (int unsigned i = 0; i < NB; i++) begin
      lo_mask[i] = (32'(i) < (32'd1 << size_eff));
    end
    acc_strobe = acc_is_store ? (lo_mask << acc_off) : '0;
    acc_data   = acc_is_store ? (in_wdata << {acc_off, 3'b000}) : '0;
  end

  always_comb begin
    ld_off = dreq_addr[LB-1:0];
    ld_raw = dresp_data >> {ld_off, 3'b000};
    case (dreq_size)
      3'd0:    ld_sign = ld_raw[7];
      3'd1:    ld_sign = ld_raw[15];
      3'd2:    ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[DATA_W-1];
    endcase
    ld_nbits = 32'd8 << dreq_size;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_ext[i] = (32'(i) < ld_nbits) ? ld_raw[i] : (ld_sign & ~lat_unsigned);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      dreq_valid   <= '0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      dreq_strobe  <= '0;
      dreq_data    <= '0;
      out_valid    <= '0;
      out_rdata    <= '0;
      out_fault    <= '0;
      lat_load     <= '0;
      lat_unsigned <= '0;
    end else if (accept) begin
      // Accept is legal from IDLE and from RESP (back-to-back), so it is
      // handled ahead of the per-state transitions.
      dreq_addr    <= acc_addr;
      dreq_size    <= size_eff;
      dreq_strobe  <= acc_strobe;
      dreq_data    <= acc_data;
      lat_load     <= (in_op == 2'b10);
      lat_unsigned <= in_unsigned;
      if (acc_is_mem & ~acc_fault) begin
        state      <= BUS;
        dreq_valid <= 1'b1;
        out_valid  <= 1'b0;
        out_fault  <= 1'b0;
      end else begin
        state      <= RESP;
        out_valid  <= 1'b1;
        out_rdata  <= '0;
        out_fault  <= acc_fault;
      end
    end else begin
      case (state)
        IDLE: ;
        BUS: begin
          if (dresp_data_ok) begin
            dreq_valid <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_rdata <= lat_load ? load_ext : '0;
              out_fault <= 1'b0;
            end
          end else if (flush) begin
            // Request stays on the bus until the outstanding beat returns
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dresp_data_ok) begin
            dreq_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        RESP: begin
          if (flush | out_ready) begin
            out_valid <= 1'b0;
            out_fault <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit (DATA_W=64, ADDR_W=64): directed scenarios
// with literal expectations plus randomized traffic, all checked every cycle
// against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata;
  logic [2:0]    in_size;
  logic          in_unsigned;
  logic          flush;
  logic          dreq_valid;
  logic [AW-1:0] dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [DW-1:0] dreq_data;
  logic          dresp_data_ok;
  logic [DW-1:0] dresp_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rdata;
  logic          out_fault;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_req, m_drain, m_res;       // request on bus / draining / result offered
  logic [63:0] m_addr, m_data, m_rdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  bit          m_store, m_load, m_uns, m_fault;

  function automatic bit m_in_ready();
    return !flush && ((!m_req && !m_drain && !m_res) || (m_res && out_ready));
  endfunction

  function automatic logic [63:0] ext_load(input logic [63:0] d, input logic [63:0] a,
                                           input logic [2:0] sz, input bit uns);
    longint unsigned off, nb;
    logic [63:0] raw, mask, v;
    off = a % 8;
    raw = d >> (8 * off);
    nb  = 8 << sz;
    if (nb >= 64) return raw;
    mask = (64'd1 << nb) - 64'd1;
    v    = raw & mask;
    if (!uns && (((v >> (nb - 1)) & 64'd1) != 0)) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit acc, is_mem, flt;
    longint unsigned sb, off;
    int unsigned st;
    if (!reset) begin
      m_req = 0; m_drain = 0; m_res = 0;
    end else begin
      acc = in_valid && m_in_ready();
      if (acc) begin
        is_mem = (in_op == 2'b10) || (in_op == 2'b11);
        sb  = 64'd1 << in_size;
        off = in_addr % sb;
`ifdef MEM_MISALIGN_TRAP_EN
        flt    = is_mem && (off != 0);
        m_addr = in_addr;
`else
        flt    = 0;
        m_addr = in_addr - off;
`endif
        m_size   = in_size;
        m_store  = (in_op == 2'b11);
        m_load   = (in_op == 2'b10);
        m_uns    = in_unsigned;
        st       = ((32'd1 << sb) - 32'd1) << (m_addr % 8);
        m_strobe = m_store ? 8'(st) : 8'h00;
        m_data   = m_store ? (in_wdata << (8 * (m_addr % 8))) : 64'd0;
        if (is_mem && !flt) begin
          m_req = 1; m_res = 0;
        end else begin
          m_res = 1; m_rdata = 0; m_fault = flt;
        end
      end else if (m_req) begin
        if (dresp_data_ok) begin
          m_req = 0;
          if (!flush) begin
            m_res   = 1;
            m_rdata = m_load ? ext_load(dresp_data, m_addr, m_size, m_uns) : 64'd0;
            m_fault = 0;
          end
        end else if (flush) begin
          m_req = 0; m_drain = 1;
        end
      end else if (m_drain) begin
        if (dresp_data_ok) m_drain = 0;
      end else if (m_res) begin
        if (flush || out_ready) m_res = 0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("dreq_valid", dreq_valid, m_req | m_drain);
      if (m_req || m_drain) begin
        chk("dreq_addr", dreq_addr, m_addr);
        chk("dreq_size", dreq_size, m_size);
        chk("dreq_strobe", dreq_strobe, m_strobe);
        if (m_store) chk("dreq_data", dreq_data, m_data);
      end
      chk("out_valid", out_valid, m_res);
      if (m_res) begin
        chk("out_rdata", out_rdata, m_rdata);
        chk("out_fault", out_fault, m_fault);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_addr = 0; in_wdata = 0; in_size = 0; in_unsigned = 0;
    flush = 0; out_ready = 1; dresp_data_ok = 0; dresp_data = 0;
  endtask

  task automatic offer(input logic [1:0] op, input logic [63:0] a, input logic [2:0] sz,
                       input logic uns, input logic [63:0] wd);
    in_valid = 1; in_op = op; in_addr = a; in_size = sz; in_unsigned = uns; in_wdata = wd;
  endtask

  int unsigned acc_cnt;

  initial begin
    idle();
    reset = 0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_dreq_addr", dreq_addr, 0);
    chk("rst_dreq_strobe", dreq_strobe, 0);
    chk("rst_dreq_data", dreq_data, 0);
    cyc();
    reset = 1;
    cmp_on = 1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    cyc();

    // Signed byte load, zero-wait bus
    offer(2'b10, 64'h1003, 3'd0, 1'b0, 64'd0);
    cyc();
    in_valid = 0; dresp_data = 64'h0000_0000_8000_0000; dresp_data_ok = 1;
    @(negedge clk);
    chk("sb_dreq_valid_c1", dreq_valid, 1);
    chk("sb_out_valid_c1", out_valid, 0);
    cyc();
    dresp_data_ok = 0;
    @(negedge clk);
    chk("sb_out_valid_c2", out_valid, 1);
    chk("sb_out_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    cyc(); cyc();

    // Half store with 3 wait cycles, then back-pressure on the result
    out_ready = 0;
    offer(2'b11, 64'h2006, 3'd1, 1'b0, 64'hBEEF);
    cyc();
    in_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      dresp_data_ok = (k == 4);
      @(negedge clk);
      chk("sh_dreq_valid", dreq_valid, 1);
      chk("sh_dreq_addr", dreq_addr, 64'h2006);
      chk("sh_dreq_size", dreq_size, 1);
      chk("sh_dreq_strobe", dreq_strobe, 8'hC0);
      chk("sh_dreq_data", dreq_data, 64'hBEEF_0000_0000_0000);
      chk("sh_in_ready_bus", in_ready, 0);
      cyc();
    end
    dresp_data_ok = 0;
    offer(2'b10, 64'h4002, 3'd1, 1'b1, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_rdata", out_rdata, 0);
      chk("bp_in_ready", in_ready, 0);
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_in_ready_release", in_ready, 1);
    cyc();
    in_valid = 0; dresp_data = 64'h1234_5678_9ABC_DEF0; dresp_data_ok = 1;
    @(negedge clk);
    chk("b2b_dreq_valid", dreq_valid, 1);
    chk("b2b_dreq_addr", dreq_addr, 64'h4002);
    cyc();
    dresp_data_ok = 0;
    @(negedge clk);
    chk("b2b_out_rdata", out_rdata, 64'h9ABC);
    cyc(); cyc();

    // Flush during BUS
    offer(2'b10, 64'h5000, 3'd3, 1'b0, 64'd0);
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("fl_dreq_valid_c1", dreq_valid, 1);
    cyc();
    flush = 1;
    @(negedge clk);
    chk("fl_in_ready_c2", in_ready, 0);
    cyc();
    flush = 0;
    @(negedge clk);
    chk("fl_dreq_valid_c3", dreq_valid, 1);
    chk("fl_out_valid_c3", out_valid, 0);
    cyc();
    dresp_data_ok = 1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("fl_dreq_valid_c4", dreq_valid, 1);
    cyc();
    dresp_data_ok = 0;
    @(negedge clk);
    chk("fl_in_ready_c5", in_ready, 1);
    chk("fl_dreq_valid_c5", dreq_valid, 0);
    chk("fl_out_valid_c5", out_valid, 0);
    cyc();

    // Misaligned word load
    offer(2'b10, 64'h3002, 3'd2, 1'b0, 64'd0);
    cyc();
    in_valid = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("mis_out_fault", out_fault, 1);
    chk("mis_out_valid", out_valid, 1);
    chk("mis_dreq_valid", dreq_valid, 0);
`else
    dresp_data_ok = 1;
    @(negedge clk);
    chk("mis_dreq_valid", dreq_valid, 1);
    chk("mis_dreq_addr", dreq_addr, 64'h3000);
`endif
    cyc();
    dresp_data_ok = 0;
    cyc(); cyc();

    // Reset while a store is on the bus
    offer(2'b11, 64'h6008, 3'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
    cyc();
    in_valid = 0; reset = 0;
    @(negedge clk);
    chk("rb_dreq_valid_c1", dreq_valid, 1);
    cyc();
    reset = 1;
    @(negedge clk);
    chk("rb_dreq_valid", dreq_valid, 0);
    chk("rb_dreq_addr", dreq_addr, 0);
    chk("rb_dreq_data", dreq_data, 0);
    chk("rb_dreq_strobe", dreq_strobe, 0);
    chk("rb_dreq_size", dreq_size, 0);
    chk("rb_out_valid", out_valid, 0);
    chk("rb_out_rdata", out_rdata, 0);
    chk("rb_out_fault", out_fault, 0);
    chk("rb_in_ready", in_ready, 1);
    cyc();

    // Throughput: zero-wait bus, out_ready high, execute always offering
    acc_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      offer(2'b10, {32'd0, $urandom & 32'hFFFF_FFF8}, 3'd3, 1'b0, 64'd0);
      dresp_data = {$urandom, $urandom};
      dresp_data_ok = dreq_valid;
      @(negedge clk);
      if (in_valid && in_ready) acc_cnt++;
      cyc();
    end
    chk("throughput_accepts", acc_cnt, 10);
    idle();
    for (int k = 0; k < 4; k++) begin
      dresp_data_ok = dreq_valid;
      cyc();
    end
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 299) != 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      in_op         = 2'($urandom);
      in_addr       = {$urandom, $urandom};
      in_size       = 3'($urandom_range(0, 3));
      in_unsigned   = 1'($urandom);
      in_wdata      = {$urandom, $urandom};
      flush         = ($urandom_range(0, 19) == 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      dresp_data    = {$urandom, $urandom};
      dresp_data_ok = dreq_valid && ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle();
    reset = 1;
    for (int k = 0; k < 10; k++) begin
      dresp_data_ok = dreq_valid;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
